// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared constants and types for the RX strip FIFO
//
// Purpose : default geometry, stat counter width, write-side state encoding
//           and a saturating increment helper for the status counters.
// Ports   : none (package).
package rx_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 64;
  localparam int STAT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM, registered read, single clock
//
// Purpose : FIFO word storage (data plus tlast flag).
// Ports   : clk             - clock
//           wr_en/wr_addr/wr_data - write port
//           rd_en/rd_addr   - read request; rd_data valid the cycle after
//           rd_data         - registered read data, held while rd_en is low
module sdp_ram
  import rx_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF + 1,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_strip_fifo.sv
// rtl/rx_strip_fifo.sv - Aurora RX store-and-forward FIFO with sequence-word strip
//
// Purpose : accepts RX beats with no backpressure, optionally removes the
//           trailing sequence word of each packet, stores whole packets and
//           releases them downstream only once complete. Packets that do not
//           fit are dropped whole.
// Optional: define RX_SEQ_CHECK_EN to count sequence-number discontinuities.
// Ports   : m_axis_aclk, m_axis_areset (async, active high)
//           s_axis_tvalid/tdata/tlast  - RX input, no tready
//           m_axis_tvalid/tdata/tlast/tready - downstream stream
//           ctrl_strip_seq   - strip trailing sequence word (per packet)
//           stat_seq_last    - last sequence word seen
//           stat_drop_cnt    - packets dropped on overflow (saturating)
//           stat_seq_err_cnt - sequence discontinuities (saturating)
module rx_strip_fifo
  import rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              m_axis_aclk,
  input  logic              m_axis_areset,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  input  logic              ctrl_strip_seq,
  output logic [31:0]       stat_seq_last,
  output logic [STAT_W-1:0] stat_drop_cnt,
  output logic [STAT_W-1:0] stat_seq_err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  wr_state_e         st;
  logic              strip_pkt;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic [PW-1:0]     wr_ptr_t;   // tentative: where the next word goes
  logic [PW-1:0]     wr_ptr_c;   // committed: end of last complete packet
  logic [PW-1:0]     rd_ptr;

  logic              strip_cur;
  logic              wr_req;
  logic              wr_en;
  logic              full;
  logic              overflow;
  logic [DATA_W-1:0] wr_data;
  logic [PW-1:0]     fill;
  logic [31:0]       seq_word;

  logic              s1_valid;   // RAM output register holds a word
  logic              empty;
  logic              out_free;
  logic              rd_en;
  logic [DATA_W:0]   rd_q;

  assign seq_word = 32'(s_axis_tdata);

  // The strip setting is taken live on a packet's first beat, latched after.
  assign strip_cur = (st == ST_IDLE) ? ctrl_strip_seq : strip_pkt;

  // In strip mode a write needs a held word; the tlast beat flushes the held
  // word and the sequence word itself never enters the data path.
  assign wr_req  = s_axis_tvalid && (st != ST_DROP) && (!strip_cur || hold_valid);
  assign wr_data = strip_cur ? hold_data : s_axis_tdata;

  // Compared against the registered read pointer, so a read issued in the
  // same cycle never makes room for this write.
  assign fill     = wr_ptr_t - rd_ptr;
  assign full     = (fill == DEPTH_P);
  assign overflow = wr_req && full;
  assign wr_en    = wr_req && !full;

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      st            <= ST_IDLE;
      strip_pkt     <= 1'b0;
      hold_valid    <= 1'b0;
      hold_data     <= '0;
      wr_ptr_t      <= '0;
      wr_ptr_c      <= '0;
      stat_drop_cnt <= '0;
      stat_seq_last <= '0;
    end else begin
      if (s_axis_tvalid && s_axis_tlast) stat_seq_last <= seq_word;

      if (overflow) begin
        wr_ptr_t      <= wr_ptr_c;
        hold_valid    <= 1'b0;
        stat_drop_cnt <= sat_inc(stat_drop_cnt);
        // An overflow on the tlast beat has already consumed the whole packet.
        st            <= s_axis_tlast ? ST_IDLE : ST_DROP;
      end else if (s_axis_tvalid) begin
        if (wr_en) wr_ptr_t <= wr_ptr_t + 1'b1;
        if (wr_en && s_axis_tlast) wr_ptr_c <= wr_ptr_t + 1'b1;

        case (st)
          ST_IDLE: begin
            strip_pkt <= ctrl_strip_seq;
            if (!s_axis_tlast) st <= ST_PKT;
          end
          ST_PKT:  if (s_axis_tlast) st <= ST_IDLE;
          ST_DROP: if (s_axis_tlast) st <= ST_IDLE;
          default: st <= ST_IDLE;
        endcase

        if ((st != ST_DROP) && strip_cur && !s_axis_tlast) begin
          hold_data  <= s_axis_tdata;
          hold_valid <= 1'b1;
        end else begin
          hold_valid <= 1'b0;
        end
      end
    end
  end

`ifdef RX_SEQ_CHECK_EN
  logic              seq_seen;
  logic [STAT_W-1:0] seq_err_cnt;

  // stat_seq_last still holds the previous sequence word on a tlast beat.
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      seq_seen    <= 1'b0;
      seq_err_cnt <= '0;
    end else if (s_axis_tvalid && s_axis_tlast) begin
      seq_seen <= 1'b1;
      if (seq_seen && (seq_word != stat_seq_last + 32'd1))
        seq_err_cnt <= sat_inc(seq_err_cnt);
    end
  end

  assign stat_seq_err_cnt = seq_err_cnt;
`else
  assign stat_seq_err_cnt = '0;
`endif

  sdp_ram #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (m_axis_aclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_t[AW-1:0]),
    .wr_data ({s_axis_tlast, wr_data}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_q)
  );

  // Two-stage prefetch: RAM output register, then the output register.
  // A new read is issued whenever the RAM register is empty or moving on,
  // which keeps one word per cycle flowing.
  assign empty    = (wr_ptr_c == rd_ptr);
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign rd_en    = !empty && (!s1_valid || out_free);

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      rd_ptr        <= '0;
      s1_valid      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;

      if (rd_en)         s1_valid <= 1'b1;
      else if (out_free) s1_valid <= 1'b0;

      if (out_free) begin
        m_axis_tvalid <= s1_valid;
        if (s1_valid) begin
          m_axis_tdata <= rd_q[DATA_W-1:0];
          m_axis_tlast <= rd_q[DATA_W];
        end
      end
    end
  end

endmodule

// File: doc/rx_strip_fifo.md
RX_STRIP_FIFO -- requirements
Module: rx_strip_fifo

Interface
REQ-001 Parameter DATA_W, default 32: AXI-Stream data width in bits.
REQ-002 Parameter DEPTH, default 64: FIFO capacity in words; power of two, minimum 4.
REQ-003 m_axis_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 m_axis_areset  in  1  asynchronous, active-high reset.
REQ-005 s_axis_tvalid  in  1  Aurora RX beat valid; there is no tready, so every valid beat is presented exactly once.
REQ-006 s_axis_tdata  in  DATA_W  Aurora RX beat data.
REQ-007 s_axis_tlast  in  1  last beat of the RTDS transaction; that beat is the sequence number.
REQ-008 m_axis_tvalid / m_axis_tdata / m_axis_tlast  out  1/DATA_W/1  downstream AXI-Stream master.
REQ-009 m_axis_tready  in  1  downstream backpressure.
REQ-010 ctrl_strip_seq  in  1  when 1, the trailing sequence word is removed; sampled on each packet's first beat and held for that packet.
REQ-011 stat_seq_last  out  32  last received sequence word (low 32 bits of the tlast beat).
REQ-012 stat_drop_cnt  out  16  packets dropped on overflow; saturates at 16'hFFFF.
REQ-013 stat_seq_err_cnt  out  16  sequence discontinuities; saturates; see REQ-030.

Function
REQ-014 The write side SHALL use state machine ST_IDLE, ST_PKT, ST_DROP.
- ST_IDLE + valid + !last -> ST_PKT.
- ST_PKT + valid + last -> ST_IDLE.
- Any state + overflow -> ST_DROP.
- ST_DROP + valid + last -> ST_IDLE.
REQ-015 With strip active, each beat SHALL be delayed one beat in a hold register. On the tlast beat, the held word is written with tlast=1 and the sequence word is discarded from the data path.
REQ-016 With strip inactive, beats SHALL be written unmodified, tlast preserved.
REQ-017 A single-beat packet with strip active SHALL write nothing and update stat_seq_last only.
REQ-018 Words SHALL be written at a tentative pointer. The committed pointer SHALL advance to the tentative pointer only when a packet's tlast word is written, making the FIFO store-and-forward.
REQ-019 Full SHALL be computed as (tentative - read pointer of previous cycle) == DEPTH, using pointers one bit wider than log2(DEPTH). A read in the same cycle SHALL NOT free space for that write.
REQ-020 A write attempted while full SHALL:
- rewind the tentative pointer to the committed pointer;
- enter ST_DROP and discard beats through tlast;
- increment stat_drop_cnt once per packet.
REQ-021 The read side SHALL present only committed words through a registered output stage (first-word-fall-through).
REQ-022 The output stage SHALL follow AXI-Stream rules: tdata and tlast stable while tvalid && !tready; a beat transfers on tvalid && tready.
REQ-023 With the FIFO empty and m_axis_tready=1, m_axis_tvalid SHALL rise exactly 3 cycles after the input tlast beat.
REQ-024 Sustained throughput SHALL be one word per cycle on both sides.
REQ-025 Pointers SHALL wrap modulo 2*DEPTH without loss at any wrap position.
REQ-026 stat_seq_last SHALL update on the cycle after every tlast beat, including dropped packets.

Reset
REQ-027 Asserting m_axis_areset SHALL immediately clear:
- all pointers and the hold register;
- the state to ST_IDLE;
- m_axis_tvalid, m_axis_tlast, m_axis_tdata, and all stat outputs to 0.
REQ-028 Reset mid-packet SHALL discard the partial packet. The first beat after release SHALL be treated as a packet start.
REQ-029 RAM contents need no reset.

Configuration
REQ-030 With macro RX_SEQ_CHECK_EN defined, the block SHALL increment stat_seq_err_cnt whenever a sequence word differs from the previous one plus 1, skipping the first packet after reset. Without the macro, stat_seq_err_cnt SHALL be constant 0 and the comparator SHALL be absent.

Structure
REQ-031 Package rx_pkg SHALL hold the state encoding constants, the default DATA_W and DEPTH, and the stat counter width (16).
REQ-032 Storage SHALL be a sub-module sdp_ram: simple dual-port, one write and one read port, registered read, 1-cycle latency, same clock.

Verification
REQ-033 Strip on, packet A,B,C,seq=5, tready=1 -> output A,B,C(tlast); stat_seq_last=5; tvalid 3 cycles after seq beat.
REQ-034 Strip off, packet 1,2,seq=7 -> output 1,2,7(tlast) unchanged.
REQ-035 DEPTH=4, tready=0, 3-word committed packet, then 4-word packet -> second packet dropped, stat_drop_cnt=1, first packet intact after tready=1.
REQ-036 Strip on, single-beat packet seq=9 -> no output; stat_seq_last=9.
REQ-037 Reset asserted mid-packet, then packet X,seq -> only X(tlast) emitted; stats 0 before the new packet.
REQ-038 RX_SEQ_CHECK_EN defined, sequence words 1,2,4 -> stat_seq_err_cnt=1; 200 back-to-back packets cross pointer wrap with no loss.
